// File: rtl/out_ctl.sv
// out_ctl - output-drain controller for the fully-connected layer engine.
// When the execution controller finishes a kernel (k_fin), the accumulator
// lanes are captured into a hold register. They are then written one lane per
// cycle into the output buffer at sample*OC + lane. The write address is kept
// as a running base (base += OC per sample), so no multiplier is needed.
// Draining sample n can overlap with computing sample n+1.
// Optional build macro: OUT_CTL_RELU_EN. When defined, negative lanes are
// written as zero.

module out_ctl #(
   parameter int SAMPLE = 40,
   parameter int OC     = 10,
   parameter int DW     = 16,
   parameter int AW     = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_init,
   input  logic              k_fin,
   input  logic [OC*DW-1:0]  acc,
   input  logic              ob_ready,
   output logic              ob_we,
   output logic [AW-1:0]     ob_addr,
   output logic [DW-1:0]     ob_data,
   output logic              out_busy,
   output logic              outrf,
   output logic              err
);

   localparam int LW = (OC > 1) ? $clog2(OC) : 1;
   localparam int SW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
   localparam logic [LW-1:0] LAST_LANE   = LW'(OC - 1);
   localparam logic [SW-1:0] LAST_SAMPLE = SW'(SAMPLE - 1);
   localparam logic [AW-1:0] OC_STEP     = AW'(OC);

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   state_t        state;
   logic [DW-1:0] hold [OC];
   logic [LW-1:0] lane;
   logic [LW-1:0] lane_nxt;
   logic [SW-1:0] sample;
   logic [AW-1:0] base;
   logic          capture;
   logic          accept;
   logic          last_lane;
   logic          last_sample;

   // Output shaping: either a signed pass-through or a ReLU clamp.
   function automatic logic [DW-1:0] shape(input logic [DW-1:0] v);
`ifdef OUT_CTL_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   // A capture happens either from IDLE or together with s_init.
   // A k_fin that arrives during a drain is dropped and counted as an overrun.
   assign capture     = k_fin & (s_init | (state == IDLE));
   assign accept      = (state == DRAIN) & ob_we & ob_ready;
   assign lane_nxt    = lane + 1'b1;
   assign last_lane   = (lane == LAST_LANE);
   assign last_sample = (sample == LAST_SAMPLE);

   // Hold register: snapshot of all accumulator lanes taken on an accepted k_fin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < OC; i++) begin
            hold[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < OC; i++) begin
            hold[i] <= acc[i*DW +: DW];
         end
      end
   end

   // Drain FSM. All outputs are registered. s_init overrides every other event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         lane     <= '0;
         sample   <= '0;
         base     <= '0;
         ob_we    <= 1'b0;
         ob_addr  <= '0;
         ob_data  <= '0;
         out_busy <= 1'b0;
         outrf    <= 1'b0;
         err      <= 1'b0;
      end else begin
         outrf <= 1'b0;
         if (s_init) begin
            sample <= '0;
            base   <= '0;
            lane   <= '0;
            err    <= 1'b0;
            if (k_fin) begin
               state    <= DRAIN;
               ob_we    <= 1'b1;
               ob_addr  <= '0;
               ob_data  <= shape(acc[0 +: DW]);
               out_busy <= 1'b1;
            end else begin
               state    <= IDLE;
               ob_we    <= 1'b0;
               out_busy <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (k_fin) begin
                     state    <= DRAIN;
                     lane     <= '0;
                     ob_we    <= 1'b1;
                     ob_addr  <= base;
                     ob_data  <= shape(acc[0 +: DW]);
                     out_busy <= 1'b1;
                  end
               end
               DRAIN: begin
                  if (k_fin) begin
                     err <= 1'b1;
                  end
                  if (accept) begin
                     if (last_lane) begin
                        state    <= IDLE;
                        lane     <= '0;
                        ob_we    <= 1'b0;
                        out_busy <= 1'b0;
                        if (last_sample) begin
                           sample <= '0;
                           base   <= '0;
                           outrf  <= 1'b1;
                        end else begin
                           sample <= sample + 1'b1;
                           base   <= base + OC_STEP;
                        end
                     end else begin
                        lane    <= lane_nxt;
                        ob_addr <= ob_addr + 1'b1;
                        ob_data <= shape(hold[lane_nxt]);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_out_ctl.sv
// tb_out_ctl - self-checking bench for out_ctl.
// It combines a table of single-sample vectors, hand-written multi-cycle
// sequences, and a long randomized run. Every cycle is compared against a
// queue-based reference model of the expected output-buffer writes.

module tb_out_ctl;

   localparam int SAMPLE = 40;
   localparam int OC     = 10;
   localparam int DW     = 16;
   localparam int AW     = 9;

   logic              clk;
   logic              rst;
   logic              s_init;
   logic              k_fin;
   logic [OC*DW-1:0]  acc;
   logic              ob_ready;
   logic              ob_we;
   logic [AW-1:0]     ob_addr;
   logic [DW-1:0]     ob_data;
   logic              out_busy;
   logic              outrf;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;

   out_ctl #(
      .SAMPLE(SAMPLE),
      .OC    (OC),
      .DW    (DW),
      .AW    (AW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_init  (s_init),
      .k_fin   (k_fin),
      .acc     (acc),
      .ob_ready(ob_ready),
      .ob_we   (ob_we),
      .ob_addr (ob_addr),
      .ob_data (ob_data),
      .out_busy(out_busy),
      .outrf   (outrf),
      .err     (err)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then return at the next falling edge.
   task automatic applyStimulus(input bit si, input bit kf, input bit rd);
      s_init   = si;
      k_fin    = kf;
      ob_ready = rd;
      @(negedge clk);
   endtask

   task automatic setRamp(input int b);
      for (int i = 0; i < OC; i++) acc[i*DW +: DW] = DW'(b + i);
   endtask

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef OUT_CTL_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            last_batch;
   } wr_t;

   wr_t q[$];
   wr_t done_wr;
   int  m_sample;
   bit  m_err;
   bit  m_outrf;
   bit  m_busy_before;

   function automatic void modelCapture();
      wr_t w;
      for (int i = 0; i < OC; i++) begin
         w.addr       = AW'(m_sample * OC + i);
         w.data       = relu(acc[i*DW +: DW]);
         w.last_batch = (m_sample == SAMPLE - 1) && (i == OC - 1);
         q.push_back(w);
      end
      m_sample = (m_sample + 1) % SAMPLE;
   endfunction

   // Reference model: a pending-write queue. The controller is busy while the queue is not empty.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_sample = 0;
         m_err    = 0;
         m_outrf  = 0;
      end else begin
         m_outrf = 0;
         if (s_init) begin
            q.delete();
            m_sample = 0;
            m_err    = 0;
            if (k_fin) modelCapture();
         end else begin
            m_busy_before = (q.size() != 0);
            if (m_busy_before && ob_ready) begin
               done_wr = q.pop_front();
               if (done_wr.last_batch) m_outrf = 1;
            end
            if (k_fin) begin
               if (m_busy_before) m_err = 1;
               else modelCapture();
            end
         end
      end
   end

   // Every cycle out of reset, compare the DUT outputs with the model.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("model_we", ob_we, (q.size() != 0));
         checkOutput("model_busy", out_busy, (q.size() != 0));
         checkOutput("model_outrf", outrf, m_outrf);
         checkOutput("model_err", err, m_err);
         if (q.size() != 0) begin
            checkOutput("model_addr", ob_addr, q[0].addr);
            checkOutput("model_data", ob_data, q[0].data);
         end
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      bit s_init;
      bit k_fin;
      bit ready;
      bit e_we;
      int e_addr;
      int e_data;
      bit e_busy;
      bit e_outrf;
   } vec_t;

   vec_t vtab[OC+2];

   // Main test sequence.
   initial begin
      int bad;
      int cnt;
      int outrf_cnt;
      int outrf_at;
      int acc_addr[$];
      int last_acc_off;
      bit rd;
      logic [DW-1:0] neg_val;

      rst = 1'b0; s_init = 1'b0; k_fin = 1'b0; ob_ready = 1'b1; acc = '0;

      // Reset state
      @(negedge clk); @(negedge clk);
      checkOutput("rst_we", ob_we, 0);
      checkOutput("rst_addr", ob_addr, 0);
      checkOutput("rst_data", ob_data, 0);
      checkOutput("rst_busy", out_busy, 0);
      checkOutput("rst_outrf", outrf, 0);
      checkOutput("rst_err", err, 0);
      rst = 1'b1;
      applyStimulus(0, 0, 1);
      checkOutput("post_rst_we", ob_we, 0);

      // Single sample, driven from a table
      vtab[0] = '{1, 0, 1, 0, 0, 0, 0, 0};
      vtab[1] = '{0, 1, 1, 1, 0, 100, 1, 0};
      for (int i = 1; i < OC; i++) vtab[i+1] = '{0, 0, 1, 1, i, 100 + i, 1, 0};
      vtab[OC+1] = '{0, 0, 1, 0, 0, 0, 0, 0};
      setRamp(100);
      for (int v = 0; v < OC + 2; v++) begin
         applyStimulus(vtab[v].s_init, vtab[v].k_fin, vtab[v].ready);
         checkOutput($sformatf("tab%0d_we", v), ob_we, vtab[v].e_we);
         checkOutput($sformatf("tab%0d_busy", v), out_busy, vtab[v].e_busy);
         checkOutput($sformatf("tab%0d_outrf", v), outrf, vtab[v].e_outrf);
         if (vtab[v].e_we) begin
            checkOutput($sformatf("tab%0d_addr", v), ob_addr, vtab[v].e_addr);
            checkOutput($sformatf("tab%0d_data", v), ob_data, vtab[v].e_data);
         end
      end

      // Full batch: 40 kernels spaced 26 cycles apart
      applyStimulus(1, 0, 1);
      outrf_cnt = 0; outrf_at = -1; bad = 0;
      for (int s = 0; s < SAMPLE; s++) begin
         setRamp(s * 7);
         applyStimulus(0, 1, 1);
         for (int off = 1; off <= 25; off++) begin
            if (outrf) begin
               outrf_cnt++;
               outrf_at = s * 100 + off;
            end
            if (s == SAMPLE - 1 && off <= OC) begin
               if (!ob_we || ob_addr != AW'((SAMPLE - 1) * OC + off - 1)) bad++;
            end
            applyStimulus(0, 0, 1);
         end
      end
      checkOutput("batch_last_addrs_bad", bad, 0);
      checkOutput("batch_outrf_count", outrf_cnt, 1);
      checkOutput("batch_outrf_when", outrf_at, (SAMPLE - 1) * 100 + OC + 1);
      applyStimulus(0, 1, 1);
      checkOutput("batch_wrap_addr", ob_addr, 0);
      for (int i = 0; i < OC + 1; i++) applyStimulus(0, 0, 1);

      // Back-pressure: stall for 3 cycles while lane 4 is presented
      applyStimulus(1, 0, 1);
      setRamp(300);
      applyStimulus(0, 1, 1);
      acc_addr.delete(); last_acc_off = -1; bad = 0;
      for (int off = 1; off <= 14; off++) begin
         rd = !(off >= 5 && off <= 7);
         if (off >= 5 && off <= 7) begin
            if (ob_addr != AW'(4) || ob_data != DW'(304) || !ob_we) bad++;
         end
         if (ob_we && rd) begin
            acc_addr.push_back(int'(ob_addr));
            last_acc_off = off;
         end
         if (off == 14) checkOutput("bp_busy_end", out_busy, 0);
         applyStimulus(0, 0, rd);
      end
      checkOutput("bp_frozen_bad", bad, 0);
      checkOutput("bp_write_count", acc_addr.size(), OC);
      cnt = 0;
      foreach (acc_addr[i]) if (acc_addr[i] != i) cnt++;
      checkOutput("bp_lane_order_bad", cnt, 0);
      checkOutput("bp_last_write", last_acc_off, 13);

      // Overrun: a second k_fin at T+5
      applyStimulus(1, 0, 1);
      setRamp(200);
      applyStimulus(0, 1, 1);
      setRamp(500);
      cnt = 0; bad = 0;
      for (int off = 1; off <= 12; off++) begin
         if (ob_we) begin
            if (ob_data != DW'(200 + cnt)) bad++;
            cnt++;
         end
         if (off == 6) checkOutput("ovr_err_set", err, 1);
         applyStimulus(0, (off == 5), 1);
      end
      checkOutput("ovr_lanes_written", cnt, OC);
      checkOutput("ovr_data_bad", bad, 0);
      checkOutput("ovr_err_sticky", err, 1);
      applyStimulus(1, 0, 1);
      checkOutput("ovr_err_cleared", err, 0);
      applyStimulus(0, 1, 1);
      checkOutput("ovr_sample_zero", ob_addr, 0);
      for (int i = 0; i < OC + 1; i++) applyStimulus(0, 0, 1);

      // Abort with s_init while lane 6 is presented (sample 1)
      setRamp(40);
      applyStimulus(0, 1, 1);
      for (int off = 1; off <= 6; off++) applyStimulus(0, 0, 1);
      checkOutput("abort_lane6_addr", ob_addr, OC + 6);
      applyStimulus(1, 0, 1);
      checkOutput("abort_we", ob_we, 0);
      checkOutput("abort_busy", out_busy, 0);

      // Asynchronous reset in the middle of a drain, with err set
      applyStimulus(0, 1, 1);
      applyStimulus(0, 1, 1);
      applyStimulus(0, 0, 1);
      checkOutput("arst_pre_err", err, 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("arst_we", ob_we, 0);
      checkOutput("arst_addr", ob_addr, 0);
      checkOutput("arst_data", ob_data, 0);
      checkOutput("arst_busy", out_busy, 0);
      checkOutput("arst_outrf", outrf, 0);
      checkOutput("arst_err", err, 0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 1);
      checkOutput("arst_release_we", ob_we, 0);

      // Negative lane value: clamped to zero under ReLU, otherwise passed through
      applyStimulus(1, 0, 1);
      setRamp(1);
      neg_val = 16'hFF38;
      acc[0 +: DW] = neg_val;
      applyStimulus(0, 1, 1);
`ifdef OUT_CTL_RELU_EN
      checkOutput("relu_neg_data", ob_data, 0);
`else
      checkOutput("relu_neg_data", ob_data, 16'hFF38);
`endif
      for (int i = 0; i < OC + 1; i++) applyStimulus(0, 0, 1);

      // Randomized traffic checked against the model
      applyStimulus(1, 0, 1);
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < OC; i++) acc[i*DW +: DW] = DW'($urandom);
         applyStimulus(($urandom_range(0, 1499) == 0), ($urandom_range(0, 5) == 0),
                       ($urandom_range(0, 3) != 0));
      end
      for (int i = 0; i < 3 * OC; i++) applyStimulus(0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
